// File: rtl/bram_stack_loader.sv
// bram_stack_loader
// Write sequencer for a cascaded BRAM stack. It takes a ready/valid stream of
// W-bit words and writes them BRAM-major, meaning every address of block 0 is
// written, then every address of block 1, up to block M-1.
// The write port outputs (data, native address, block address, enable) are
// registered. After the last beat there is a one-cycle FLUSH, then a one-cycle
// DONE pulse, and after that o_loaded is high.
// Optional feature: define BRAM_STACK_LOADER_CHECKSUM_EN to build a running
// XOR checksum of the loaded words on o_checksum. Without it, o_checksum is 0.
module bram_stack_loader #(
    parameter int M              = 6,
    parameter int W              = 64,
    parameter int A              = 10,
    parameter int Ablk           = 7,
    parameter int WORDS_PER_BRAM = 1024
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [W-1:0]    i_data,
    input  logic            i_data_valid,
    output logic            o_data_ready,
    output logic [W-1:0]    o_wrdata,
    output logic [A-1:0]    o_wraddr,
    output logic [Ablk-1:0] o_wrblk_addr,
    output logic            o_wren,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_loaded,
    output logic [W-1:0]    o_checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [A-1:0]    LAST_WORD = A'(WORDS_PER_BRAM - 1);
    localparam logic [Ablk-1:0] LAST_BLK  = Ablk'(M - 1);
    localparam logic [A-1:0]    WORD_STEP = A'(1);
    localparam logic [Ablk-1:0] BLK_STEP  = Ablk'(1);

    state_t          state_reg;
    state_t          state_next;
    logic [A-1:0]    word_reg;
    logic [Ablk-1:0] blk_reg;
    logic [W-1:0]    wrdata_reg;
    logic [A-1:0]    wraddr_reg;
    logic [Ablk-1:0] wrblk_reg;
    logic            wren_reg;
    logic            loaded_reg;
    logic            ready;
    logic            accept;
    logic            last_beat;
    logic            start_load;

    // A start pulse only counts in IDLE. It is ignored in LOAD, FLUSH and DONE.
    assign start_load = (state_reg == IDLE) && i_start;
    assign accept     = ready && i_data_valid;
    // The block counter is the full Ablk width, so no zero-extension is
    // needed on the block address path.
    assign last_beat  = accept && (word_reg == LAST_WORD) && (blk_reg == LAST_BLK);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: LOAD until the final beat, then FLUSH, DONE, and back to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_load) state_next = LOAD;
            LOAD:    if (last_beat)  state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        ready  = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_reg)
            LOAD: begin
                ready  = 1'b1;
                o_busy = 1'b1;
            end
            FLUSH: begin
                o_busy = 1'b1;
            end
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: begin
                ready  = 1'b0;
            end
        endcase
    end

    // Word and block counters: the word counter wraps at the end of a BRAM and advances the block
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_reg <= '0;
            blk_reg  <= '0;
        end else if (start_load) begin
            word_reg <= '0;
            blk_reg  <= '0;
        end else if (accept) begin
            if (word_reg == LAST_WORD) begin
                word_reg <= '0;
                blk_reg  <= blk_reg + BLK_STEP;
            end else begin
                word_reg <= word_reg + WORD_STEP;
            end
        end
    end

    // Registered write port: enable follows each accept; data and addresses hold while idle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wren_reg   <= 1'b0;
            wrdata_reg <= '0;
            wraddr_reg <= '0;
            wrblk_reg  <= '0;
        end else begin
            wren_reg <= accept;
            if (accept) begin
                wrdata_reg <= i_data;
                wraddr_reg <= word_reg;
                wrblk_reg  <= blk_reg;
            end
        end
    end

    // Loaded flag: cleared when a load starts, set as the FSM enters DONE
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            loaded_reg <= 1'b0;
        end else if (start_load) begin
            loaded_reg <= 1'b0;
        end else if (state_reg == FLUSH) begin
            loaded_reg <= 1'b1;
        end
    end

    assign o_data_ready = ready;
    assign o_wren       = wren_reg;
    assign o_wrdata     = wrdata_reg;
    assign o_wraddr     = wraddr_reg;
    assign o_wrblk_addr = wrblk_reg;
    assign o_loaded     = loaded_reg;

`ifdef BRAM_STACK_LOADER_CHECKSUM_EN
    logic [W-1:0] checksum_reg;

    // Running XOR of accepted beats. It only changes in LOAD, so it holds from DONE until the next start.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            checksum_reg <= '0;
        end else if (start_load) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg ^ i_data;
        end
    end

    assign o_checksum = checksum_reg;
`else
    assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_bram_stack_loader.sv
// Testbench for bram_stack_loader.
// A small instance (M=2, WORDS_PER_BRAM=4) covers the cycle-level scenarios.
// A default-parameter instance covers the full 6144-beat load.
// The reference model gives the k-th write of a load:
//   block   = k / WORDS_PER_BRAM
//   address = k % WORDS_PER_BRAM
//   data    = the k-th word of the stimulus table
// It also expects the write one cycle after the accept and o_done two cycles
// after the last accept.
module tb_bram_stack_loader;

    localparam int SW   = 64;
    localparam int SM   = 2;
    localparam int SWPB = 4;
    localparam int SN   = SM * SWPB;
    localparam int DM   = 6;
    localparam int DWPB = 1024;
    localparam int DN   = DM * DWPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Small instance signals
    logic          s_reset, s_start, s_valid;
    logic [SW-1:0] s_data;
    logic          s_ready, s_wren, s_busy, s_done, s_loaded;
    logic [SW-1:0] s_wrdata, s_checksum;
    logic [9:0]    s_wraddr;
    logic [6:0]    s_wrblk;

    // Default instance signals
    logic          d_reset, d_start, d_valid;
    logic [SW-1:0] d_data;
    logic          d_ready, d_wren, d_busy, d_done, d_loaded;
    logic [SW-1:0] d_wrdata, d_checksum;
    logic [9:0]    d_wraddr;
    logic [6:0]    d_wrblk;

    bram_stack_loader #(.M(SM), .W(SW), .A(10), .Ablk(7), .WORDS_PER_BRAM(SWPB)) dut_s (
        .i_clk(clk), .i_reset(s_reset), .i_start(s_start), .i_data(s_data),
        .i_data_valid(s_valid), .o_data_ready(s_ready), .o_wrdata(s_wrdata),
        .o_wraddr(s_wraddr), .o_wrblk_addr(s_wrblk), .o_wren(s_wren),
        .o_busy(s_busy), .o_done(s_done), .o_loaded(s_loaded), .o_checksum(s_checksum)
    );

    bram_stack_loader dut_d (
        .i_clk(clk), .i_reset(d_reset), .i_start(d_start), .i_data(d_data),
        .i_data_valid(d_valid), .o_data_ready(d_ready), .o_wrdata(d_wrdata),
        .o_wraddr(d_wraddr), .o_wrblk_addr(d_wrblk), .o_wren(d_wren),
        .o_busy(d_busy), .o_done(d_done), .o_loaded(d_loaded), .o_checksum(d_checksum)
    );

    // Event log for the small instance, sampled on the falling edge
    logic [SW-1:0] acc_data[$];
    int            acc_cyc[$];
    logic [SW-1:0] wr_data[$];
    int            wr_addr[$];
    int            wr_blk[$];
    int            wr_cyc[$];
    int            done_cyc[$];
    logic          done_loaded[$];
    logic [SW-1:0] done_ck[$];
    int            hold_err = 0;
    logic [SW-1:0] last_data = '0;
    logic [9:0]    last_addr = '0;
    logic [6:0]    last_blk  = '0;

    always @(negedge clk) begin
        if (s_reset) begin
            last_data = '0;
            last_addr = '0;
            last_blk  = '0;
        end else begin
            if (s_valid && s_ready) begin
                acc_data.push_back(s_data);
                acc_cyc.push_back(cyc);
            end
            if (s_wren) begin
                wr_data.push_back(s_wrdata);
                wr_addr.push_back(int'(s_wraddr));
                wr_blk.push_back(int'(s_wrblk));
                wr_cyc.push_back(cyc);
                last_data = s_wrdata;
                last_addr = s_wraddr;
                last_blk  = s_wrblk;
            end else if (s_wrdata !== last_data || s_wraddr !== last_addr || s_wrblk !== last_blk) begin
                hold_err++;
            end
            if (s_done) begin
                done_cyc.push_back(cyc);
                done_loaded.push_back(s_loaded);
                done_ck.push_back(s_checksum);
            end
        end
    end

    // Monitor for the default instance: counts writes that disagree with the model
    localparam logic [SW-1:0] D_BASE = 64'hA5A5_0000_0000_0000;
    int d_acc = 0, d_wr = 0, d_bad = 0, d_done_n = 0;
    int d_last_blk = -1, d_last_addr = -1;
    always @(negedge clk) begin
        if (!d_reset) begin
            if (d_valid && d_ready) d_acc++;
            if (d_wren) begin
                if (int'(d_wrblk) != d_wr / DWPB || int'(d_wraddr) != d_wr % DWPB ||
                    d_wrdata !== D_BASE + SW'(d_wr))
                    d_bad++;
                d_last_blk  = int'(d_wrblk);
                d_last_addr = int'(d_wraddr);
                d_wr++;
            end
            if (d_done) d_done_n++;
        end
    end

    logic [SW-1:0] pat_tab[16];

    // Runs one small load. vmode: 0 = valid always high, 1 = valid toggling, 2 = random valid.
    // start_at >= 0 repeats the start pulse at that LOAD cycle.
    task automatic drive_s(input int vmode, input int start_at, input int abase,
                           output int end_cyc, output bit tmo);
        int idx;
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        tmo = 1'b1;
        end_cyc = -1;
        for (int it = 0; it < 200; it++) begin
            idx = acc_data.size() - abase;
            s_data  = pat_tab[(idx < 16) ? idx : 15];
            s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (it % 2 == 0) : 1'($urandom_range(0, 1));
            s_start = (it == start_at);
            @(posedge clk); #1;
            if (!s_busy) begin
                end_cyc = cyc;
                tmo = 1'b0;
                break;
            end
        end
        s_valid = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic test_reset;
        s_reset = 1'b1; d_reset = 1'b1;
        s_start = 1'b0; d_start = 1'b0;
        s_valid = 1'b0; d_valid = 1'b0;
        s_data = '0; d_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s_ready, s_wren, s_busy, s_done, s_loaded, s_wrdata, s_wraddr, s_wrblk, s_checksum} !== '0) begin
            $display("FAIL reset_small: got ready=%b wren=%b busy=%b done=%b loaded=%b data=%h addr=%0d blk=%0d ck=%h, want all 0",
                     s_ready, s_wren, s_busy, s_done, s_loaded, s_wrdata, s_wraddr, s_wrblk, s_checksum);
        end else n_pass++;
        n_checks++;
        if ({d_ready, d_wren, d_busy, d_done, d_loaded, d_wrdata, d_wraddr, d_wrblk, d_checksum} !== '0) begin
            $display("FAIL reset_default: got ready=%b wren=%b busy=%b done=%b loaded=%b, want all 0",
                     d_ready, d_wren, d_busy, d_done, d_loaded);
        end else n_pass++;
        s_reset = 1'b0; d_reset = 1'b0;
        s_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s_ready, s_busy, s_wren} !== 3'b000) begin
            $display("FAIL idle_no_start: got ready=%b busy=%b wren=%b want 000", s_ready, s_busy, s_wren);
        end else n_pass++;
        s_valid = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_single;
        int ab, wb, db, end_cyc, k;
        bit tmo;
        for (int i = 0; i < 16; i++) pat_tab[i] = SW'(i);
        ab = acc_data.size(); wb = wr_data.size(); db = done_cyc.size();
        drive_s(0, -1, ab, end_cyc, tmo);
        n_checks++;
        if (tmo || acc_data.size() - ab != SN || wr_data.size() - wb != SN) begin
            $display("FAIL single_count: got tmo=%0d accepts=%0d writes=%0d want 0/%0d/%0d",
                     tmo, acc_data.size() - ab, wr_data.size() - wb, SN, SN);
        end else n_pass++;
        if (!tmo && wr_data.size() - wb == SN && acc_data.size() - ab == SN) begin
            for (k = 0; k < SN; k++) begin
                n_checks++;
                if (wr_blk[wb+k] != k / SWPB || wr_addr[wb+k] != k % SWPB || wr_data[wb+k] !== pat_tab[k] ||
                    wr_cyc[wb+k] != wr_cyc[wb] + k || wr_cyc[wb+k] != acc_cyc[ab+k] + 1) begin
                    $display("FAIL single_write%0d: got (%0d,%0d) data=%h cyc=%0d want (%0d,%0d) data=%h cyc=%0d",
                             k, wr_blk[wb+k], wr_addr[wb+k], wr_data[wb+k], wr_cyc[wb+k],
                             k / SWPB, k % SWPB, pat_tab[k], acc_cyc[ab+k] + 1);
                end else n_pass++;
            end
            n_checks++;
            if (done_cyc.size() - db != 1) begin
                $display("FAIL single_done_count: got %0d want 1", done_cyc.size() - db);
            end else begin
                n_pass++;
                n_checks++;
                if (done_cyc[db] != acc_cyc[ab+SN-1] + 2 || done_loaded[db] !== 1'b1 || end_cyc != done_cyc[db] + 1) begin
                    $display("FAIL single_done_timing: got done=%0d loaded=%b idle=%0d want done=%0d loaded=1 idle=%0d",
                             done_cyc[db], done_loaded[db], end_cyc, acc_cyc[ab+SN-1] + 2, acc_cyc[ab+SN-1] + 3);
                end else n_pass++;
            end
        end
        n_checks++;
        if (s_loaded !== 1'b1) begin
            $display("FAIL single_loaded: got %b want 1", s_loaded);
        end else n_pass++;
        $display("test_single: %0d writes", wr_data.size() - wb);
    endtask

    task automatic test_stall(input int vmode);
        int ab, wb, db, end_cyc, h0, k;
        bit tmo;
        for (int i = 0; i < 16; i++) pat_tab[i] = {$urandom, $urandom};
        ab = acc_data.size(); wb = wr_data.size(); db = done_cyc.size(); h0 = hold_err;
        drive_s(vmode, -1, ab, end_cyc, tmo);
        n_checks++;
        if (tmo || wr_data.size() - wb != SN || acc_data.size() - ab != SN || done_cyc.size() - db != 1) begin
            $display("FAIL stall%0d_count: got tmo=%0d writes=%0d accepts=%0d dones=%0d want 0/%0d/%0d/1",
                     vmode, tmo, wr_data.size() - wb, acc_data.size() - ab, done_cyc.size() - db, SN, SN);
        end else begin
            n_pass++;
            for (k = 0; k < SN; k++) begin
                n_checks++;
                if (wr_blk[wb+k] != k / SWPB || wr_addr[wb+k] != k % SWPB || wr_data[wb+k] !== pat_tab[k] ||
                    wr_cyc[wb+k] != acc_cyc[ab+k] + 1) begin
                    $display("FAIL stall%0d_write%0d: got (%0d,%0d) data=%h cyc=%0d want (%0d,%0d) data=%h cyc=%0d",
                             vmode, k, wr_blk[wb+k], wr_addr[wb+k], wr_data[wb+k], wr_cyc[wb+k],
                             k / SWPB, k % SWPB, pat_tab[k], acc_cyc[ab+k] + 1);
                end else n_pass++;
            end
            n_checks++;
            if (done_cyc[db] != acc_cyc[ab+SN-1] + 2) begin
                $display("FAIL stall%0d_done: got cyc %0d want %0d", vmode, done_cyc[db], acc_cyc[ab+SN-1] + 2);
            end else n_pass++;
        end
        n_checks++;
        if (hold_err != h0) begin
            $display("FAIL stall%0d_hold: got %0d changes while wren=0 want 0", vmode, hold_err - h0);
        end else n_pass++;
        $display("test_stall mode %0d: %0d writes", vmode, wr_data.size() - wb);
    endtask

    task automatic test_start_while_busy;
        int ab, wb, db, end_cyc;
        bit tmo;
        for (int i = 0; i < 16; i++) pat_tab[i] = SW'(100 + i);
        ab = acc_data.size(); wb = wr_data.size(); db = done_cyc.size();
        drive_s(0, 3, ab, end_cyc, tmo);
        n_checks++;
        if (tmo || wr_data.size() - wb != SN || done_cyc.size() - db != 1) begin
            $display("FAIL busy_start: got tmo=%0d writes=%0d dones=%0d want 0/%0d/1",
                     tmo, wr_data.size() - wb, done_cyc.size() - db, SN);
        end else n_pass++;
        n_checks++;
        if (wr_data.size() - wb == SN && (wr_blk[wb+SN-1] != SM - 1 || wr_addr[wb+SN-1] != SWPB - 1 ||
            wr_data[wb+SN-1] !== pat_tab[SN-1])) begin
            $display("FAIL busy_last_write: got (%0d,%0d) data=%h want (%0d,%0d) data=%h",
                     wr_blk[wb+SN-1], wr_addr[wb+SN-1], wr_data[wb+SN-1], SM - 1, SWPB - 1, pat_tab[SN-1]);
        end else n_pass++;
        $display("test_start_while_busy: %0d writes", wr_data.size() - wb);
    endtask

    task automatic test_reset_mid_load;
        int ab, wb, db, end_cyc, it;
        bit tmo;
        for (int i = 0; i < 16; i++) pat_tab[i] = SW'(32'hC0DE_0000 + i);
        ab = acc_data.size(); db = done_cyc.size();
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_valid = 1'b1;
        for (it = 0; it < 50; it++) begin
            if (acc_data.size() - ab >= 5) break;
            s_data = pat_tab[acc_data.size() - ab];
            @(posedge clk); #1;
        end
        n_checks++;
        if (it >= 50) begin
            $display("FAIL midreset_reach5: got %0d accepts want 5", acc_data.size() - ab);
        end else n_pass++;
        s_valid = 1'b0;
        s_reset = 1'b1;
        #1;
        n_checks++;
        if ({s_ready, s_wren, s_busy, s_done, s_loaded, s_wrdata, s_wraddr, s_wrblk, s_checksum} !== '0) begin
            $display("FAIL midreset_outputs: got ready=%b wren=%b busy=%b done=%b loaded=%b data=%h addr=%0d blk=%0d ck=%h, want all 0",
                     s_ready, s_wren, s_busy, s_done, s_loaded, s_wrdata, s_wraddr, s_wrblk, s_checksum);
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        s_reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done_cyc.size() != db || s_busy !== 1'b0) begin
            $display("FAIL midreset_no_done: got dones=%0d busy=%b want 0/0", done_cyc.size() - db, s_busy);
        end else n_pass++;
        ab = acc_data.size(); wb = wr_data.size();
        drive_s(0, -1, ab, end_cyc, tmo);
        n_checks++;
        if (tmo || wr_data.size() - wb != SN || wr_blk[wb] != 0 || wr_addr[wb] != 0 || wr_data[wb] !== pat_tab[0]) begin
            $display("FAIL midreset_reload: got tmo=%0d writes=%0d first=(%0d,%0d) want 0/%0d first=(0,0)",
                     tmo, wr_data.size() - wb, (wr_data.size() > wb) ? wr_blk[wb] : -1,
                     (wr_data.size() > wb) ? wr_addr[wb] : -1, SN);
        end else n_pass++;
        $display("test_reset_mid_load: reload %0d writes", wr_data.size() - wb);
    endtask

    task automatic test_checksum;
        int ab, db, end_cyc;
        bit tmo;
        logic [SW-1:0] exp_ck;
        for (int i = 0; i < 16; i++) pat_tab[i] = SW'(1) << i;
`ifdef BRAM_STACK_LOADER_CHECKSUM_EN
        exp_ck = 64'hFF;
`else
        exp_ck = 64'h0;
`endif
        ab = acc_data.size(); db = done_cyc.size();
        drive_s(2, -1, ab, end_cyc, tmo);
        n_checks++;
        if (tmo || done_cyc.size() - db != 1) begin
            $display("FAIL checksum_done: got tmo=%0d dones=%0d want 0/1", tmo, done_cyc.size() - db);
        end else begin
            n_pass++;
            n_checks++;
            if (done_ck[db] !== exp_ck) begin
                $display("FAIL checksum_value: got %h want %h", done_ck[db], exp_ck);
            end else n_pass++;
        end
        n_checks++;
        if (s_checksum !== exp_ck) begin
            $display("FAIL checksum_hold: got %h want %h", s_checksum, exp_ck);
        end else n_pass++;
        $display("test_checksum: checksum %h", s_checksum);
    endtask

    task automatic test_default_full;
        bit tmo;
        logic [SW-1:0] exp_ck;
        exp_ck = '0;
`ifdef BRAM_STACK_LOADER_CHECKSUM_EN
        for (int k = 0; k < DN; k++) exp_ck ^= D_BASE + SW'(k);
`endif
        @(posedge clk); #1;
        d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        tmo = 1'b1;
        for (int it = 0; it < DN + 100; it++) begin
            d_data  = D_BASE + SW'(d_acc);
            d_valid = 1'b1;
            @(posedge clk); #1;
            if (!d_busy) begin
                tmo = 1'b0;
                break;
            end
        end
        d_valid = 1'b0;
        n_checks++;
        if (tmo || d_acc != DN || d_wr != DN || d_bad != 0) begin
            $display("FAIL default_stream: got tmo=%0d accepts=%0d writes=%0d bad=%0d want 0/%0d/%0d/0",
                     tmo, d_acc, d_wr, d_bad, DN, DN);
        end else n_pass++;
        n_checks++;
        if (d_last_blk != DM - 1 || d_last_addr != DWPB - 1) begin
            $display("FAIL default_last: got (%0d,%0d) want (%0d,%0d)", d_last_blk, d_last_addr, DM - 1, DWPB - 1);
        end else n_pass++;
        n_checks++;
        if (d_done_n != 1 || d_loaded !== 1'b1 || d_checksum !== exp_ck) begin
            $display("FAIL default_done: got dones=%0d loaded=%b ck=%h want 1/1/%h", d_done_n, d_loaded, d_checksum, exp_ck);
        end else n_pass++;
        $display("test_default_full: %0d writes, last (%0d,%0d)", d_wr, d_last_blk, d_last_addr);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall(1);
        test_stall(2);
        test_start_while_busy();
        test_reset_mid_load();
        test_checksum();
        test_default_full();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
